// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel push-button debouncer.
// Optional auto-repeat is enabled by defining DEBOUNCE_REPEAT_EN.
package debounce_pkg;

    localparam int DEF_TICK_HZ      = 1000;
    localparam int DEF_STABLE_TICKS = 20;

    // Never returns 0 so a counter of a degenerate range still has one bit.
    function automatic int clog2w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/debounce_if.sv
// Button bundle between board pins and the debouncer: raw inputs in, conditioned level and pulses out.
interface debounce_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btnin;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_repeat;

    modport master (
        output btnin,
        input  btn_level, btn_press, btn_release, btn_repeat
    );

    modport slave (
        input  btnin,
        output btn_level, btn_press, btn_release, btn_repeat
    );
endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: 2-FF synchroniser, stability counter, level and one-cycle pulse registers.
// Auto-repeat counter is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic press,
    output logic rels,
    output logic rpt
);
    localparam int CW = clog2w(STABLE_TICKS + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = tick && (s2 != level) && (cnt == CW'(STABLE_TICKS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rels  <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            press <= 1'b0;
            rels  <= 1'b0;
            if (accept) begin
                level <= s2;
                cnt   <= '0;
                press <= s2;
                rels  <= ~s2;
            end else if (tick) begin
                cnt <= (s2 == level) ? '0 : cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW = clog2w(REPEAT_DELAY + 1);

    logic [RW-1:0] rcnt;

    // After a pulse the counter rewinds by REPEAT_PERIOD, so REPEAT_PERIOD <= REPEAT_DELAY is assumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt <= '0;
            rpt  <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (!level || accept) begin
                rcnt <= '0;
            end else if (tick) begin
                if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                    rpt  <= 1'b1;
                    rcnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: shared sample-tick prescaler, polarity fix-up, per-channel debounce.
// Define DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat counters.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int CLK_HZ        = 125000000,
    parameter int TICK_HZ       = DEF_TICK_HZ,
    parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic      clk,
    input  logic      rst_n,
    debounce_if.slave bus
);
    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = clog2w(DIV);

    logic [PW-1:0]   pcnt;
    logic            tick;
    logic [N_CH-1:0] din;
    logic [N_CH-1:0] level_v, press_v, rels_v, rpt_v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (pcnt == PW'(DIV - 1)) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = (pcnt == PW'(DIV - 1));
    assign din  = (ACTIVE_LOW != 0) ? ~bus.btnin : bus.btnin;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .din  (din[i]),
            .level(level_v[i]),
            .press(press_v[i]),
            .rels (rels_v[i]),
            .rpt  (rpt_v[i])
        );
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = rels_v;
    assign bus.btn_repeat  = rpt_v;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus pushes expected pulse events, a monitor pops and compares them.
module tb_debounce_multi;
    localparam int N_CH = 4;
    localparam int DIV  = 10;
    localparam int ST   = 3;
    localparam int RD   = 5;
    localparam int RP   = 2;

    typedef struct {
        int       at;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] rp;
    } ev_t;

    logic clk;
    logic rst_n;
    int   ecount;
    int   tests;
    int   fails;
    ev_t  q[$];

    debounce_if #(.N_CH(N_CH)) bus ();

    debounce_multi #(
        .N_CH         (N_CH),
        .CLK_HZ       (1000),
        .TICK_HZ      (100),
        .STABLE_TICKS (ST),
        .ACTIVE_LOW   (0),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge number since the last reset edge; ticks are consumed on edges that are multiples of DIV.
    always @(posedge clk) ecount <= rst_n ? ecount + 1 : 0;

    // Input changed after edge e0: visible in the synchroniser output after e0+2, accepted on the ST-th tick.
    function automatic int exp_edge(input int e0);
        int t;
        t = e0 + 3;
        while (t % DIV != 0) t++;
        return t + DIV * (ST - 1);
    endfunction

    task automatic push_ev(input int at, input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] rp);
        ev_t ev;
        ev.at = at;
        ev.pr = pr;
        ev.rl = rl;
        ev.rp = rp;
        q.push_back(ev);
    endtask

    // Press on e_on, release on e_off; extra = channels whose press lands on the release edge.
    task automatic push_hold(input logic [3:0] mask, input int e_on, input int e_off, input logic [3:0] extra);
        int p;
        int r;
        p = exp_edge(e_on);
        r = exp_edge(e_off);
        push_ev(p, mask, 4'b0000, 4'b0000);
`ifdef DEBOUNCE_REPEAT_EN
        for (int a = p + RD * DIV; a < r; a += RP * DIV) push_ev(a, 4'b0000, 4'b0000, mask);
`endif
        push_ev(r, extra, mask, 4'b0000);
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic wait_edge(input int n);
        while (ecount < n) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout pending=%0d next_edge=%0d now=%0d", q.size(), q[0].at, ecount);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (|{bus.btn_press, bus.btn_release, bus.btn_repeat})) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse edge=%0d press=%b release=%b repeat=%b expected none",
                         ecount, bus.btn_press, bus.btn_release, bus.btn_repeat);
            end else begin
                ev_t ev;
                ev = q.pop_front();
                if (ev.at != ecount || ev.pr !== bus.btn_press || ev.rl !== bus.btn_release
                    || ev.rp !== bus.btn_repeat) begin
                    fails++;
                    $display("FAIL pulse_event got edge=%0d p=%b r=%b rp=%b expected edge=%0d p=%b r=%b rp=%b",
                             ecount, bus.btn_press, bus.btn_release, bus.btn_repeat,
                             ev.at, ev.pr, ev.rl, ev.rp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", ecount);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int e0;
        int t1;
        tests = 0;
        fails = 0;
        ecount = 0;
        bus.btnin = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_level", bus.btn_level, 4'b0000);
        check("reset_press", bus.btn_press, 4'b0000);
        check("reset_release", bus.btn_release, 4'b0000);
        check("reset_repeat", bus.btn_repeat, 4'b0000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Long hold on ch0, then release ch0 and press ch3 on the same cycle
        e0 = ecount;
        bus.btnin[0] = 1'b1;
        push_hold(4'b0001, e0, e0 + 100, 4'b1000);
        wait_edge(e0 + 60);
        check("hold_level", bus.btn_level, 4'b0001);
        wait_edge(e0 + 100);
        bus.btnin[0] = 1'b0;
        bus.btnin[3] = 1'b1;
        drain(200);
        check("swap_level", bus.btn_level, 4'b1000);
        e0 = ecount;
        bus.btnin[3] = 1'b0;
        push_ev(exp_edge(e0), 4'b0000, 4'b1000, 4'b0000);
        drain(100);
        check("ch3_release_level", bus.btn_level, 4'b0000);

        // Bouncing ch1, phased so a tick sees the final low gap
        while (ecount % DIV != 1) @(negedge clk);
        e0 = ecount;
        for (int k = 0; k < 10; k++) begin
            bus.btnin[1] = (k % 2 == 0);
            repeat (4) @(negedge clk);
        end
        check("bounce_no_level", bus.btn_level, 4'b0000);
        bus.btnin[1] = 1'b1;
        push_ev(exp_edge(e0 + 40), 4'b0010, 4'b0000, 4'b0000);
        drain(100);
        check("bounce_level", bus.btn_level, 4'b0010);
        e0 = ecount;
        bus.btnin[1] = 1'b0;
        push_ev(exp_edge(e0), 4'b0000, 4'b0010, 4'b0000);
        drain(100);

        // Short glitch on ch2 is discarded
        bus.btnin[2] = 1'b1;
        repeat (15) @(negedge clk);
        bus.btnin[2] = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch_level", bus.btn_level, 4'b0000);

        // Reset after two qualifying ticks; qualification restarts from zero
        e0 = ecount;
        bus.btnin[2] = 1'b1;
        t1 = e0 + 3;
        while (t1 % DIV != 0) t1++;
        wait_edge(t1 + DIV);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_level", bus.btn_level, 4'b0000);
        check("midreset_press", bus.btn_press, 4'b0000);
        rst_n = 1'b1;
        push_ev(DIV * ST, 4'b0100, 4'b0000, 4'b0000);
        drain(100);
        check("midreset_relevel", bus.btn_level, 4'b0100);
        e0 = ecount;
        bus.btnin[2] = 1'b0;
        push_ev(exp_edge(e0), 4'b0000, 4'b0100, 4'b0000);
        drain(100);

        // Long hold on ch0 for auto-repeat (no repeat pulses expected without the macro)
        e0 = ecount;
        bus.btnin[0] = 1'b1;
        push_hold(4'b0001, e0, e0 + 150, 4'b0000);
        wait_edge(e0 + 150);
        check("hold2_level", bus.btn_level, 4'b0001);
        bus.btnin[0] = 1'b0;
        drain(200);
        check("final_level", bus.btn_level, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
